// File: rtl/load_store_unit_if.sv
// Memory-side valid/ready port of the load/store unit: request, write data and
// byte enables out, acceptance and read-data return in.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: runs one byte/half/word access over a valid/ready memory
// port, stalls the core until it finishes, and aborts with bus_error on timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        lsu_done,
    output logic [31:0] load_data,
    output logic        addr_fault,
    output logic        bus_error,
    load_store_unit_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic        we_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic [31:0] load_data_reg;
    logic        bus_error_reg;

    logic        is_byte, is_half, is_word;
    logic        funct3_legal, misaligned, access, fault_cond, start;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rdata_shifted;
    logic [31:0] load_extract;
    logic        expired, timeout_hit, load_capture;

    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = (funct3[1:0] == 2'b10);

    always_comb begin
        funct3_legal = 1'b0;
        if (is_store)
            funct3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            funct3_legal = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
    end

    assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign access     = lsu_valid && (is_load || is_store);
    assign fault_cond = misaligned || !funct3_legal || (is_load && is_store);
    assign start      = (state_reg == IDLE) && access && !fault_cond;
    assign addr_fault = (state_reg == IDLE) && access && fault_cond;

    always_comb begin
        be_calc = 4'b1111;
        if (is_byte)
            be_calc = 4'b0001 << addr[1:0];
        else if (is_half)
            be_calc = 4'b0011 << addr[1:0];
    end

    // Replicate the low byte/half across all lanes so any enabled lane sees the right data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                if (is_byte)
                    wdata_calc[8*gi +: 8] = store_data[7:0];
                else if (is_half)
                    wdata_calc[8*gi +: 8] = store_data[8*(gi%2) +: 8];
                else
                    wdata_calc[8*gi +: 8] = store_data[8*gi +: 8];
            end
        end
    endgenerate

    assign rdata_shifted = mem.mem_rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        case (funct3_reg)
            3'b000:  load_extract = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_extract = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_extract = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_extract = {16'd0, rdata_shifted[15:0]};
            default: load_extract = rdata_shifted;
        endcase
    end

    // ">=" so a load accepted on the expiry cycle still times out one WAIT cycle later.
    assign expired      = (cnt_reg >= TIMEOUT_LAST);
    assign load_capture = (state_reg == WAIT) && mem.mem_rvalid;
    assign timeout_hit  = ((state_reg == REQ) && !mem.mem_ready && expired) ||
                          ((state_reg == WAIT) && !mem.mem_rvalid && expired);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                if (mem.mem_ready)
                    state_next = we_reg ? DONE : WAIT;
                else if (expired)
                    state_next = DONE;
            end
            WAIT: if (mem.mem_rvalid || expired) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall          = start || (state_reg == REQ) || (state_reg == WAIT);
    assign lsu_done       = (state_reg == DONE);
    assign load_data      = load_data_reg;
    assign bus_error      = bus_error_reg;
    assign mem.mem_req    = (state_reg == REQ);
    assign mem.mem_we     = (state_reg == REQ) && we_reg;
    assign mem.mem_addr   = (state_reg == REQ) ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign mem.mem_be     = (state_reg == REQ) ? be_reg : 4'd0;
    assign mem.mem_wdata  = (state_reg == REQ) ? wdata_reg : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg       <= '0;
            addr_reg      <= 32'd0;
            funct3_reg    <= 3'd0;
            we_reg        <= 1'b0;
            be_reg        <= 4'd0;
            wdata_reg     <= 32'd0;
            load_data_reg <= 32'd0;
            bus_error_reg <= 1'b0;
        end else begin
            bus_error_reg <= timeout_hit;
            if (start) begin
                cnt_reg    <= '0;
                addr_reg   <= addr;
                funct3_reg <= funct3;
                we_reg     <= is_store;
                be_reg     <= be_calc;
                wdata_reg  <= wdata_calc;
            end else if ((state_reg == REQ) || (state_reg == WAIT)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (load_capture)
                load_data_reg <= load_extract;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and randomized accesses
// compared against a behavioural model of sizes, lanes, extension and timeout.
module tb_load_store_unit;
    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsu_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, lsu_done, addr_fault, bus_error;
    logic [31:0] load_data;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .lsu_valid(lsu_valid), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .lsu_done(lsu_done), .load_data(load_data),
        .addr_fault(addr_fault), .bus_error(bus_error),
        .mem(bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_ld;

    // Observations of the most recent run_op
    bit          o_fault, o_done, o_done_extra, o_berr, o_req_in_done, o_stall_in_done, o_unstable;
    int          o_stall_n, o_req_n;
    logic [3:0]  o_be;
    logic        o_we;
    logic [31:0] o_maddr, o_wdata, o_ld;

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n = size_of(f3);
        return 4'(((1 << n) - 1) << (n == 4 ? 0 : a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int n = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = size_of(f3);
        logic [31:0] v, mask;
        v = rd >> (8 * a[1:0]);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        v = v & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Cycles spent in REQ+WAIT and whether the access times out.
    function automatic int model_busy(input bit ld, input int rlat, input int vlat, output bit to);
        int c, lim, fin;
        c = rlat + 1;
        to = 1'b0;
        if (c > T) begin to = 1'b1; return T; end
        if (!ld) return c;
        lim = (c + 1 > T) ? c + 1 : T;
        fin = c + vlat + 1;
        if (fin <= lim) return fin;
        to = 1'b1;
        return lim;
    endfunction

    function automatic int model_reqs(input int rlat);
        return (rlat + 1 > T) ? T : rlat + 1;
    endfunction

    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int rlat, input int vlat);
        int w_n = 0;
        o_done = 0; o_done_extra = 0; o_berr = 0; o_req_in_done = 0; o_stall_in_done = 0;
        o_unstable = 0; o_req_n = 0; o_be = 'x; o_we = 'x; o_maddr = 'x; o_wdata = 'x; o_ld = 'x;
        lsu_valid = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        #1;
        o_fault = addr_fault;
        o_stall_n = int'(stall);
        @(posedge clock); #1;
        lsu_valid = 0; is_load = 0; is_store = 0;
        funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
        if (o_fault) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.mem_req) o_req_n++;
                if (stall) o_stall_n++;
                @(posedge clock); #1;
            end
            return;
        end
        for (int cyc = 0; cyc < 40 && !o_done; cyc++) begin
            if (lsu_done) begin
                o_done = 1; o_berr = bus_error; o_req_in_done = bus.mem_req;
                o_stall_in_done = stall; o_ld = load_data;
                @(posedge clock); #1;
                o_done_extra = lsu_done;
            end else begin
                if (stall) o_stall_n++;
                if (bus.mem_req) begin
                    if (o_req_n == 0) begin
                        o_be = bus.mem_be; o_we = bus.mem_we; o_maddr = bus.mem_addr; o_wdata = bus.mem_wdata;
                    end else if (o_be !== bus.mem_be || o_maddr !== bus.mem_addr || o_wdata !== bus.mem_wdata) begin
                        o_unstable = 1;
                    end
                    o_req_n++;
                    bus.mem_ready  = (o_req_n > rlat);
                    bus.mem_rvalid = 1'($urandom_range(0, 1));
                    bus.mem_rdata  = $urandom;
                end else if (stall) begin
                    w_n++;
                    bus.mem_rvalid = (w_n > vlat);
                    bus.mem_rdata  = bus.mem_rvalid ? rd : $urandom;
                end
                @(posedge clock); #1;
                bus.mem_ready = 0; bus.mem_rvalid = 0;
            end
        end
    endtask

    // Compare one completed access against the model; shared by directed and random scenarios.
    task automatic test_access(input string tag, input bit ld, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] rd, input int rlat, input int vlat);
        bit to;
        int busy;
        busy = model_busy(ld, rlat, vlat, to);
        run_op(ld, !ld, f3, a, sd, rd, rlat, vlat);
        if (ld && !to) exp_ld = model_ext(f3, a, rd);
        checks++;
        if (o_done !== 1'b1 || o_fault !== 1'b0) begin
            errors++; $display("FAIL %s done: done=%0b fault=%0b required done=1 fault=0", tag, o_done, o_fault);
        end
        checks++;
        if (o_stall_n != busy + 1 || o_stall_in_done !== 1'b0) begin
            errors++; $display("FAIL %s stall: cycles=%0d in_done=%0b required %0d,0", tag, o_stall_n, o_stall_in_done, busy + 1);
        end
        checks++;
        if (o_req_n != model_reqs(rlat) || o_unstable || o_req_in_done !== 1'b0) begin
            errors++; $display("FAIL %s req: cycles=%0d unstable=%0b in_done=%0b required %0d,0,0", tag, o_req_n, o_unstable, o_req_in_done, model_reqs(rlat));
        end
        checks++;
        if (o_be !== model_be(f3, a) || o_we !== !ld || o_maddr !== {a[31:2], 2'b00}) begin
            errors++; $display("FAIL %s bus: be=%b we=%b addr=%h required %b %b %h", tag, o_be, o_we, o_maddr, model_be(f3, a), !ld, {a[31:2], 2'b00});
        end
        if (!ld) begin
            checks++;
            if (o_wdata !== model_wdata(f3, sd)) begin
                errors++; $display("FAIL %s wdata: got %h required %h", tag, o_wdata, model_wdata(f3, sd));
            end
        end
        checks++;
        if (o_berr !== to) begin
            errors++; $display("FAIL %s bus_error: got %0b required %0b", tag, o_berr, to);
        end
        checks++;
        if (o_ld !== exp_ld) begin
            errors++; $display("FAIL %s load_data: got %h required %h", tag, o_ld, exp_ld);
        end
        checks++;
        if (o_done_extra !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse: lsu_done stayed high a second cycle", tag);
        end
        $display("%s ld=%0b f3=%b addr=%h rlat=%0d vlat=%0d stall=%0d berr=%0b load_data=%h",
                 tag, ld, f3, a, rlat, vlat, o_stall_n, o_berr, o_ld);
    endtask

    task automatic test_reset;
        reset = 0;
        lsu_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        exp_ld = 32'd0;
        checks++;
        if (bus.mem_req !== 1'b0 || stall !== 1'b0 || lsu_done !== 1'b0 || addr_fault !== 1'b0) begin
            errors++; $display("FAIL reset ctrl: req=%b stall=%b done=%b fault=%b required all 0", bus.mem_req, stall, lsu_done, addr_fault);
        end
        checks++;
        if (load_data !== 32'd0 || bus_error !== 1'b0) begin
            errors++; $display("FAIL reset data: load_data=%h bus_error=%b required 0,0", load_data, bus_error);
        end
        checks++;
        if (bus.mem_be !== 4'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL reset bus: be=%b addr=%h wdata=%h we=%b required 0", bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
        $display("reset released: load_data=%h stall=%b", load_data, stall);
    endtask

    task automatic test_directed;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] as  [4] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002};
        logic [31:0] rds [4] = '{32'h8012_3456, 32'h8012_3456, 32'hBEEF_1234, 32'hBEEF_1234};
        logic [31:0] exps[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_BEEF};
        test_access("sw_directed", 0, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            test_access("load_directed", 1, f3s[i], as[i], 32'h0, rds[i], 0, 0);
            checks++;
            if (o_ld !== exps[i]) begin
                errors++; $display("FAIL load_const%0d: got %h required %h", i, o_ld, exps[i]);
            end
        end
    endtask

    task automatic test_faults;
        bit          lds [6] = '{0, 1, 1, 1, 1, 0};
        bit          sts [6] = '{1, 0, 0, 0, 1, 1};
        logic [2:0]  f3s [6] = '{3'b001, 3'b011, 3'b010, 3'b101, 3'b000, 3'b100};
        logic [31:0] as  [6] = '{32'h3001, 32'h4000, 32'h4002, 32'h4003, 32'h4000, 32'h4000};
        logic [31:0] keep;
        for (int i = 0; i < 6; i++) begin
            keep = exp_ld;
            run_op(lds[i], sts[i], f3s[i], as[i], $urandom, 32'h0, 0, 0);
            checks++;
            if (o_fault !== 1'b1 || o_req_n != 0 || o_stall_n != 0) begin
                errors++; $display("FAIL fault%0d: fault=%0b req=%0d stall=%0d required 1,0,0", i, o_fault, o_req_n, o_stall_n);
            end
            checks++;
            if (load_data !== keep) begin
                errors++; $display("FAIL fault%0d load_data: got %h required %h", i, load_data, keep);
            end
            $display("fault ld=%0b st=%0b f3=%b addr=%h addr_fault=%0b", lds[i], sts[i], f3s[i], as[i], o_fault);
        end
    endtask

    task automatic test_timeout;
        test_access("lw_timeout", 1, 3'b010, 32'h5000, 32'h0, 32'h1111_2222, 100, 0);
        test_access("sw_ready_at_expiry", 0, 3'b010, 32'h5004, 32'hCAFE_F00D, 32'h0, T - 1, 0);
        test_access("lw_rvalid_at_expiry", 1, 3'b010, 32'h5008, 32'h0, 32'h3333_4444, 1, T - 3);
        test_access("lw_rvalid_late", 1, 3'b010, 32'h500C, 32'h0, 32'h5555_6666, 1, T - 2);
        test_access("lh_accept_at_expiry", 1, 3'b001, 32'h5012, 32'h0, 32'h7777_8888, T - 1, 0);
    endtask

    task automatic test_random;
        logic [2:0]  ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] a;
        bit          ld;
        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? ldf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a  = $urandom & ~32'(size_of(f3) - 1);
            test_access("random", ld, f3, a, $urandom, $urandom, $urandom_range(0, T), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_access(input bit in_wait);
        lsu_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h6000; store_data = 0;
        @(posedge clock); #1;
        lsu_valid = 0; is_load = 0;
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++; $display("FAIL mid_reset setup: mem_req=%b required 1", bus.mem_req);
        end
        if (in_wait) begin
            bus.mem_ready = 1;
            @(posedge clock); #1;
            bus.mem_ready = 0;
        end
        #2; reset = 0; #1;
        checks++;
        if (bus.mem_req !== 1'b0 || stall !== 1'b0 || lsu_done !== 1'b0 || bus.mem_be !== 4'd0) begin
            errors++; $display("FAIL mid_reset drop: req=%b stall=%b done=%b be=%b required 0", bus.mem_req, stall, lsu_done, bus.mem_be);
        end
        checks++;
        if (load_data !== 32'd0 || bus_error !== 1'b0) begin
            errors++; $display("FAIL mid_reset data: load_data=%h bus_error=%b required 0,0", load_data, bus_error);
        end
        @(negedge clock); reset = 1;
        exp_ld = 32'd0;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
            @(posedge clock); #1;
            checks++;
            if (stall !== 1'b0 || lsu_done !== 1'b0 || load_data !== 32'd0 || bus.mem_req !== 1'b0) begin
                errors++; $display("FAIL late_rvalid: stall=%b done=%b req=%b load_data=%h required 0", stall, lsu_done, bus.mem_req, load_data);
            end
        end
        bus.mem_rvalid = 0;
        $display("reset mid %s: load_data=%h stall=%b", in_wait ? "WAIT" : "REQ", load_data, stall);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_faults();
        test_timeout();
        test_random();
        test_reset_mid_access(1'b1);
        test_reset_mid_access(1'b0);
        test_access("post_reset_lbu", 1, 3'b100, 32'h7001, 32'h0, 32'hA5C3_9F11, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
